// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: ECP5 PLL lock qualifier and staggered domain reset sequencer; PLL_SUP_RETRY_LIMIT_EN enables the sticky retry-limit FAULT state
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS         = 3,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 17
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic                   fault
);
  typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABILIZE, RELEASE, RUN, FAULT} state_t;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [7:0]             retry, retry_n, relock_n;
  logic                   s1, lk, pll_rst_n, ready_n, fault_n, loss;
  logic [NUM_DOMAINS-1:0] dom_n;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1           <= 1'b0;
      lk           <= 1'b0;
      state        <= PLL_RESET;
      cnt          <= '0;
      retry        <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      ready        <= 1'b0;
      relock_count <= '0;
      fault        <= 1'b0;
    end else begin
      s1           <= pll_locked;
      lk           <= s1;
      state        <= state_n;
      cnt          <= cnt_n;
      retry        <= retry_n;
      pll_rst      <= pll_rst_n;
      domain_rst_n <= dom_n;
      ready        <= ready_n;
      relock_count <= relock_n;
      fault        <= fault_n;
    end
  end
  assign loss = (state == RELEASE || state == RUN) && !lk;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    retry_n   = retry;
    pll_rst_n = pll_rst;
    dom_n     = domain_rst_n;
    ready_n   = ready;
    relock_n  = relock_count;
    fault_n   = fault;
    case (state)
      PLL_RESET: begin
        pll_rst_n = 1'b1;
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          pll_rst_n = 1'b0;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_n = STABILIZE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_n   = PLL_RESET;
          cnt_n     = '0;
          pll_rst_n = 1'b1;
          retry_n   = (retry == 8'(MAX_RETRIES)) ? retry : retry + 8'd1;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          if (retry_n == 8'(MAX_RETRIES)) begin
            state_n = FAULT;
            fault_n = 1'b1;
          end
`endif
        end
      end
      STABILIZE: begin
        if (!lk) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = RELEASE;
          cnt_n   = '0;
          retry_n = '0;
        end
      end
      RELEASE: begin
        for (int i = 0; i < NUM_DOMAINS; i++)
          if (cnt == CNT_W'(i * STAGGER_CYCLES)) dom_n[i] = 1'b1;
        if (cnt == CNT_W'((NUM_DOMAINS - 1) * STAGGER_CYCLES)) begin
          state_n = RUN;
          ready_n = 1'b1;
        end
      end
      RUN:     cnt_n = '0;
      FAULT:   cnt_n = cnt;
      default: state_n = PLL_RESET;
    endcase
    // lock loss in RELEASE or RUN drops every domain at once and restarts the PLL
    if (loss) begin
      state_n   = PLL_RESET;
      cnt_n     = '0;
      pll_rst_n = 1'b1;
      dom_n     = '0;
      ready_n   = 1'b0;
      relock_n  = (relock_count == 8'd255) ? relock_count : relock_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard bench; expected output changes are queued with their cycle, a negedge monitor pops on every change
module tb_pll_lock_supervisor;
  logic       clock = 1'b0, reset_n = 1'b0, pll_locked = 1'b0;
  logic       pll_rst, ready, fault;
  logic [2:0] domain_rst_n;
  logic [7:0] relock_count;
  int         cyc = 0, tests = 0, fails = 0;
  typedef struct { int c; logic [13:0] v; } exp_t;
  exp_t        q[$];
  logic [13:0] last_v = 'x, prev = 'x;

  pll_lock_supervisor #(
    .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .STAGGER_CYCLES(4), .MAX_RETRIES(4), .CNT_W(17)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .domain_rst_n(domain_rst_n), .ready(ready), .relock_count(relock_count), .fault(fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int c, input logic p, input logic [2:0] d, input logic r, input logic [7:0] k, input logic f);
    exp_t e;
    e.c = c;
    e.v = {p, d, r, k, f};
    if (e.v !== last_v) q.push_back(e);
    last_v = e.v;
  endtask

  task automatic push_release(input int s, input logic [7:0] k);
    push(s + 9,  1'b0, 3'b001, 1'b0, k, 1'b0);
    push(s + 13, 1'b0, 3'b011, 1'b0, k, 1'b0);
    push(s + 17, 1'b0, 3'b111, 1'b1, k, 1'b0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // reset asserted mid high-phase so the outputs must clear before any clock edge
  task automatic do_reset(input logic lk_val, output int e0);
    @(posedge clock);
    #2;
    reset_n    = 1'b0;
    pll_locked = lk_val;
    push(cyc, 1'b1, 3'b000, 1'b0, 8'd0, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    e0      = cyc;
  endtask

  always @(negedge clock) begin
    logic [13:0] cur;
    exp_t        e;
    cur = {pll_rst, domain_rst_n, ready, relock_count, fault};
    if (cur !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got {rst,dom,rdy,cnt,flt}=%b, no change required", cyc, cur);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || cyc != e.c) begin
          fails++;
          $display("FAIL output_event got %b at cyc %0d, required %b at cyc %0d", cur, cyc, e.v, e.c);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    int e0, t, l;
    logic [7:0] k;
    push(1, 1'b1, 3'b000, 1'b0, 8'd0, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    e0      = cyc;
    push(e0 + 4, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
    wait_cyc(e0 + 10);
    pll_locked = 1'b1;
    push_release(e0 + 13, 8'd0);
    wait_cyc(e0 + 34);
    for (int n = 1; n <= 256; n++) begin
      t = cyc;
      k = (n > 255) ? 8'd255 : 8'(n);
      pll_locked = 1'b0;
      push(t + 3, 1'b1, 3'b000, 1'b0, k, 1'b0);
      @(negedge clock);
      pll_locked = 1'b1;
      push(t + 7, 1'b0, 3'b000, 1'b0, k, 1'b0);
      push_release(t + 8, k);
      wait_cyc(t + 27);
    end
    t = cyc;
    pll_locked = 1'b0;
    push(t + 3, 1'b1, 3'b000, 1'b0, 8'd255, 1'b0);
    @(negedge clock);
    pll_locked = 1'b1;
    push(t + 7,  1'b0, 3'b000, 1'b0, 8'd255, 1'b0);
    push(t + 17, 1'b0, 3'b001, 1'b0, 8'd255, 1'b0);
    push(t + 21, 1'b0, 3'b011, 1'b0, 8'd255, 1'b0);
    wait_cyc(t + 22);
    do_reset(1'b1, e0);
    push(e0 + 4, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
    push_release(e0 + 5, 8'd0);
    wait_cyc(e0 + 25);
    do_reset(1'b0, e0);
    push(e0 + 4, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
    l = e0 + 6;
    wait_cyc(l);
    pll_locked = 1'b1;
    wait_cyc(l + 5);
    pll_locked = 1'b0;
    wait_cyc(l + 8);
    pll_locked = 1'b1;
    push_release(l + 11, 8'd0);
    wait_cyc(l + 32);
    do_reset(1'b0, e0);
    push(e0 + 4, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
`ifdef PLL_SUP_RETRY_LIMIT_EN
    for (int r = 0; r < 3; r++) begin
      push(e0 + 36 + 36 * r, 1'b1, 3'b000, 1'b0, 8'd0, 1'b0);
      push(e0 + 40 + 36 * r, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
    end
    push(e0 + 144, 1'b1, 3'b000, 1'b0, 8'd0, 1'b1);
    wait_cyc(e0 + 150);
    pll_locked = 1'b1;
    wait_cyc(e0 + 200);
    pll_locked = 1'b0;
`else
    for (int r = 0; r < 4; r++) begin
      push(e0 + 36 + 36 * r, 1'b1, 3'b000, 1'b0, 8'd0, 1'b0);
      push(e0 + 40 + 36 * r, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
    end
    wait_cyc(e0 + 150);
`endif
    do_reset(1'b0, e0);
    push(e0 + 4, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
    wait_cyc(e0 + 10);
    repeat (3) @(negedge clock);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_event got no change, required %b at cyc %0d", e.v, e.c);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
